seq_det_param: RTL and testbench

Parametrised Moore-style serial pattern detector for the sequential FSM library. It generalises the fixed 4-bit non-overlapping detector in three ways:
- runtime-loadable pattern of width `PAT_W`;
- selectable overlapping or non-overlapping matching;
- input qualifier, so bits are consumed only when valid.

An optional saturating match counter is available. The block sits between a serial bit source and control logic that needs a one-cycle hit pulse.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/seq_det_sat_cnt.sv | 35 +++
 rtl/seq_det_param.sv | 101 ++++++++++
 tb/tb_seq_det_param.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and types for the parametrised serial pattern detector.
// Holds the legal PAT_W range, the default reset pattern and the fill counter type.
package seq_det_pkg;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;

    localparam logic [3:0] DEF_RST_PAT = 4'b1001;

    // Wide enough to hold any fill value from 0 up to PAT_W_MAX.
    localparam int FILL_W = $clog2(PAT_W_MAX + 1);
    typedef logic [FILL_W-1:0] fill_t;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear and increment enable.
// Clear has priority over increment; the count holds at all-ones.
module seq_det_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Moore serial pattern detector: runtime-loadable pattern, overlap select, valid qualifier.
// Define SEQ_DET_CNT_EN to add the saturating match counter and its match_cnt port.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(DEF_RST_PAT),
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic             din,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap_en,
    output logic             dout
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX)) begin : g_bad_pat_w
        $error("seq_det_param: PAT_W out of range");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_det_param: CNT_W must be at least 1");
    end

    localparam fill_t FILL_FULL = fill_t'(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    fill_t            fill_q, fill_d;
    logic             hit_q, hit_d;

    logic [PAT_W-1:0] hist_acc;
    fill_t            fill_acc;
    logic             match;

    // din is consumed on an edge only when din_vld is high and pat_ld is low;
    // there is no backpressure, the source may present a bit on any cycle.
    always_comb begin
        pat_d    = pat_q;
        hist_d   = hist_q;
        fill_d   = fill_q;
        hit_d    = 1'b0;
        match    = 1'b0;
        hist_acc = PAT_W'({hist_q, din});
        fill_acc = (fill_q >= FILL_FULL) ? FILL_FULL : (fill_q + fill_t'(1));

        if (pat_ld) begin
            pat_d  = pat_in;
            fill_d = '0;
        end else if (din_vld) begin
            hist_d = hist_acc;
            fill_d = fill_acc;
            // Compare against the updated history so the completing bit counts.
            if ((fill_acc == FILL_FULL) && (hist_acc == pat_q)) begin
                match = 1'b1;
                hit_d = 1'b1;
                if (!overlap_en) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= RST_PAT;
            hist_q <= '0;
            fill_q <= '0;
            hit_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            hit_q  <= hit_d;
        end
    end

    assign dout = hit_q;

`ifdef SEQ_DET_CNT_EN
    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pat_ld),
        .inc (match),
        .cnt (match_cnt)
    );
`else
    logic unused_match;
    assign unused_match = match;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Directed bench for seq_det_param: a PAT_W=4 instance for the main cases and a
// PAT_W=2 / CNT_W=2 overlap instance for continuous and saturating matches.
module tb_seq_det_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       din_vld, din, pat_ld, overlap_en;
    logic [3:0] pat_in;
    logic       dout;
    logic       din_vld2, din2;
    logic       pat_ld2;
    logic [1:0] pat_in2;
    logic       overlap_en2;
    logic       dout2;
`ifdef SEQ_DET_CNT_EN
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_det_param #(
        .PAT_W   (4),
        .RST_PAT (4'b1001),
        .CNT_W   (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din_vld    (din_vld),
        .din        (din),
        .pat_ld     (pat_ld),
        .pat_in     (pat_in),
        .overlap_en (overlap_en),
        .dout       (dout)
`ifdef SEQ_DET_CNT_EN
        ,
        .match_cnt  (match_cnt)
`endif
    );

    seq_det_param #(
        .PAT_W   (2),
        .RST_PAT (2'b11),
        .CNT_W   (2)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .din_vld    (din_vld2),
        .din        (din2),
        .pat_ld     (pat_ld2),
        .pat_in     (pat_in2),
        .overlap_en (overlap_en2),
        .dout       (dout2)
`ifdef SEQ_DET_CNT_EN
        ,
        .match_cnt  (match_cnt2)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("reset_dout", {15'd0, dout}, 16'd0);
`ifdef SEQ_DET_CNT_EN
        chk("reset_cnt", {8'd0, match_cnt}, 16'd0);
`endif
        rst = 1'b0;
    endtask

    task automatic send(input string tag, input logic v, input logic d, input logic exp_dout);
        din_vld = v;
        din     = d;
        pat_ld  = 1'b0;
        tick();
        chk(tag, {15'd0, dout}, {15'd0, exp_dout});
    endtask

    task automatic load(input logic [3:0] p, input logic v, input logic d);
        pat_ld  = 1'b1;
        pat_in  = p;
        din_vld = v;
        din     = d;
        tick();
        pat_ld  = 1'b0;
        din_vld = 1'b0;
        chk("load_dout", {15'd0, dout}, 16'd0);
    endtask

    logic [6:0] stream7;
    logic [6:0] exp_nov;
    logic [6:0] exp_ov;

    initial begin
        rst = 1'b1; din_vld = 1'b0; din = 1'b0; pat_ld = 1'b0; pat_in = 4'd0;
        overlap_en = 1'b0;
        din_vld2 = 1'b0; din2 = 1'b0; pat_ld2 = 1'b0; pat_in2 = 2'b00; overlap_en2 = 1'b1;
        stream7 = 7'b1001001;
        exp_nov = 7'b0001000;
        exp_ov  = 7'b0001001;
        @(negedge clk);

        // Reset pattern 1001, non-overlap: one pulse after bit 4.
        do_reset();
        overlap_en = 1'b0;
        for (int i = 6; i >= 0; i--) send("nov_stream", 1'b1, stream7[i], exp_nov[i]);
        send("nov_idle", 1'b0, 1'b0, 1'b0);

        // Same stream with overlap: pulses after bits 4 and 7.
        do_reset();
        overlap_en = 1'b1;
        for (int i = 6; i >= 0; i--) send("ov_stream", 1'b1, stream7[i], exp_ov[i]);
        send("ov_idle", 1'b0, 1'b0, 1'b0);
`ifdef SEQ_DET_CNT_EN
        chk("ov_cnt", {8'd0, match_cnt}, 16'd2);
`endif

        // Reload 0110 with a valid bit in the load cycle; that bit is discarded.
        overlap_en = 1'b0;
        load(4'b0110, 1'b1, 1'b1);
`ifdef SEQ_DET_CNT_EN
        chk("ld_cnt_clr", {8'd0, match_cnt}, 16'd0);
`endif
        send("ld_b1", 1'b1, 1'b0, 1'b0);
        send("ld_b2", 1'b1, 1'b1, 1'b0);
        send("ld_b3", 1'b1, 1'b1, 1'b0);
        send("ld_b4", 1'b1, 1'b0, 1'b1);
`ifdef SEQ_DET_CNT_EN
        chk("ld_cnt_one", {8'd0, match_cnt}, 16'd1);
`endif
        // Load-cycle 0 followed by 1,1,0 would match only if the load bit counted.
        load(4'b0110, 1'b1, 1'b0);
        send("ldx_b1", 1'b1, 1'b1, 1'b0);
        send("ldx_b2", 1'b1, 1'b1, 1'b0);
        send("ldx_b3", 1'b1, 1'b0, 1'b0);

        // Valid gaps: three idle cycles between bits of 1001.
        do_reset();
        send("gap_b1", 1'b1, 1'b1, 1'b0);
        for (int j = 0; j < 3; j++) send("gap_idle1", 1'b0, 1'b1, 1'b0);
        send("gap_b2", 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) send("gap_idle2", 1'b0, 1'b1, 1'b0);
        send("gap_b3", 1'b1, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) send("gap_idle3", 1'b0, 1'b1, 1'b0);
        send("gap_b4", 1'b1, 1'b1, 1'b1);
        for (int j = 0; j < 3; j++) send("gap_idle4", 1'b0, 1'b1, 1'b0);

        // Asynchronous reset clears a live pulse between edges.
        do_reset();
        send("ar_b1", 1'b1, 1'b1, 1'b0);
        send("ar_b2", 1'b1, 1'b0, 1'b0);
        send("ar_b3", 1'b1, 1'b0, 1'b0);
        send("ar_b4", 1'b1, 1'b1, 1'b1);
        din_vld = 1'b0;
        #2 rst = 1'b1;
        #1 chk("ar_async_dout", {15'd0, dout}, 16'd0);
`ifdef SEQ_DET_CNT_EN
        chk("ar_async_cnt", {8'd0, match_cnt}, 16'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Reset after three bits discards the partial sequence.
        send("mr_b1", 1'b1, 1'b1, 1'b0);
        send("mr_b2", 1'b1, 1'b0, 1'b0);
        send("mr_b3", 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk("mr_rst_dout", {15'd0, dout}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        send("mr_b4", 1'b1, 1'b1, 1'b0);

        // Leading-zero pattern needs a full PAT_W bits of history each time.
        load(4'b0000, 1'b0, 1'b0);
        overlap_en = 1'b0;
        for (int j = 0; j < 3; j++) send("lz_first", 1'b1, 1'b0, 1'b0);
        send("lz_hit1", 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) send("lz_second", 1'b1, 1'b0, 1'b0);
        send("lz_hit2", 1'b1, 1'b0, 1'b1);

        // Pattern 11, overlap, continuous 1s on the narrow instance.
        do_reset();
        din_vld = 1'b0;
        din_vld2 = 1'b1;
        din2 = 1'b1;
        tick();
        chk("sat_b1_dout", {15'd0, dout2}, 16'd0);
        for (int k = 2; k <= 6; k++) begin
            tick();
            chk("sat_dout", {15'd0, dout2}, 16'd1);
`ifdef SEQ_DET_CNT_EN
            chk("sat_cnt", {14'd0, match_cnt2}, (k >= 4) ? 16'd3 : 16'(k - 1));
`endif
        end
        din_vld2 = 1'b0;
        tick();
        chk("sat_idle_dout", {15'd0, dout2}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
